// File: rtl/uart_pkg.sv
// Shared constants for the serial-debug UART receive path: defaults, FSM state codes,
// bit-timer modes and the counter-width helper.
package uart_pkg;

  localparam int DEFAULT_OSR       = 16;
  localparam int DEFAULT_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic {
    MODE_HALF = 1'b0,
    MODE_FULL = 1'b1
  } timer_mode_t;

  // Smallest width w (at least 1) with 2**w >= n.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample-tick counter for the UART receiver. It emits a one-clk 'due' strobe at
// half a bit (start qualification) or at a full bit (data, parity and stop sampling).
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OSR = DEFAULT_OSR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fr_div,
  input  logic        clear,
  input  timer_mode_t mode,
  output logic        due
);

  localparam int CW = cnt_width(OSR);

  logic          tick;
  logic [CW-1:0] cnt;
  logic [CW-1:0] target;

  assign tick   = ~fr_div;
  assign target = (mode == MODE_HALF) ? CW'(OSR / 2 - 1) : CW'(OSR - 1);
  assign due    = tick && !clear && (cnt == target);

  // Every compare restarts the count, so cnt never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      if (clear || (cnt == target)) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: qualifies the start bit, samples data mid-bit, checks the stop bit.
// Define UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OSR       = DEFAULT_OSR,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fr_div,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 vld_rx,
  output logic                 frm_err,
  output logic                 busy,
  output logic                 par_err
);

  localparam int IDX_W = cnt_width(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rxd_meta;
  logic                 rxd_s;
  logic [2:0]           state;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 armed;
  logic                 tick;
  logic                 due;
  logic                 timer_clear;
  timer_mode_t          timer_mode;

  assign tick        = ~fr_div;
  assign busy        = (state != ST_IDLE);
  assign timer_clear = (state == ST_IDLE);
  assign timer_mode  = (state == ST_START) ? MODE_HALF : MODE_FULL;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  uart_bit_timer #(
    .OSR (OSR)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .fr_div (fr_div),
    .clear  (timer_clear),
    .mode   (timer_mode),
    .due    (due)
  );

`ifdef UART_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  // A low stop bit disarms start detection until the line is seen high again,
  // so a break or stuck-low line cannot spawn endless frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      shift   <= '0;
      rx_data <= '0;
      vld_rx  <= 1'b0;
      frm_err <= 1'b0;
      armed   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      vld_rx  <= 1'b0;
      frm_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q <= 1'b0;
`endif
      if (tick) begin
        if (rxd_s) armed <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (armed && !rxd_s) state <= ST_START;
          end
          ST_START: begin
            if (rxd_s) begin
              state <= ST_IDLE;
            end else if (due) begin
              state <= ST_DATA;
              idx   <= '0;
            end
          end
          ST_DATA: begin
            if (due) begin
              shift <= {rxd_s, shift[DATA_BITS-1:1]};
              idx   <= idx + 1'b1;
              if (idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            if (due) begin
              par_bad <= (^shift) ^ rxd_s;
              state   <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            if (due) begin
              if (rxd_s) begin
                rx_data <= shift;
                vld_rx  <= 1'b1;
              end else begin
                frm_err <= 1'b1;
                armed   <= 1'b0;
              end
`ifdef UART_PARITY_EN
              par_err_q <= par_bad;
`endif
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
